// File: rtl/mult_pkg.sv
// Shared types and defaults for the two-client shift-add multiplier controller.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic client_id_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: A/B/P registers, one add-and-shift per step.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]   sum;

    // The carry out of the add lands in the top of P as {sum, A} shifts right.
    always_comb begin
        sum = {1'b0, p_q} + (a_q[0] ? {1'b0, b_q} : '0);
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (load_i) begin
            a_d = a_i;
            b_d = b_i;
            p_d = '0;
        end else if (step_i) begin
            {p_d, a_d} = {sum, a_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign prod_o = {p_q, a_q};

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one shift-add multiplier between two clients.
// Optional MULT_PERF_CNT_EN adds a saturating 16-bit ops_done handshake counter.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c0_req_valid,
    output logic               c0_req_ready,
    input  logic [WIDTH-1:0]   c0_a,
    input  logic [WIDTH-1:0]   c0_b,
    output logic               c0_resp_valid,
    input  logic               c0_resp_ready,
    output logic [2*WIDTH-1:0] c0_result,
    input  logic               c1_req_valid,
    output logic               c1_req_ready,
    input  logic [WIDTH-1:0]   c1_a,
    input  logic [WIDTH-1:0]   c1_b,
    output logic               c1_resp_valid,
    input  logic               c1_resp_ready,
    output logic [2*WIDTH-1:0] c1_result,
    output logic               busy,
    output logic               grant_id
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [15:0]        ops_done
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    client_id_t         grant_q, grant_d;
    client_id_t         ptr_q, ptr_d;
    client_id_t         winner;
    logic               anyReq;
    logic               dpLoad;
    logic               dpStep;
    logic               respHs;
    logic [WIDTH-1:0]   selA;
    logic [WIDTH-1:0]   selB;
    logic [2*WIDTH-1:0] prod;

    // Lone requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        anyReq = c0_req_valid | c1_req_valid;
        if (c0_req_valid && !c1_req_valid) begin
            winner = 1'b0;
        end else if (c1_req_valid && !c0_req_valid) begin
            winner = 1'b1;
        end else begin
            winner = ptr_q;
        end
        selA = winner ? c1_a : c0_a;
        selB = winner ? c1_b : c0_b;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        dpLoad        = 1'b0;
        dpStep        = 1'b0;
        respHs        = 1'b0;
        c0_req_ready  = 1'b0;
        c1_req_ready  = 1'b0;
        c0_resp_valid = 1'b0;
        c1_resp_valid = 1'b0;
        c0_result     = '0;
        c1_result     = '0;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    dpLoad       = 1'b1;
                    grant_d      = winner;
                    cnt_d        = '0;
                    c0_req_ready = (winner == 1'b0);
                    c1_req_ready = (winner == 1'b1);
                    state_d      = CALC;
                end
            end
            CALC: begin
                dpStep = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                c0_resp_valid = (grant_q == 1'b0);
                c1_resp_valid = (grant_q == 1'b1);
                c0_result     = (grant_q == 1'b0) ? prod : '0;
                c1_result     = (grant_q == 1'b1) ? prod : '0;
                respHs        = grant_q ? c1_resp_ready : c0_resp_ready;
                if (respHs) begin
                    ptr_d   = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = busy ? grant_q : 1'b0;

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (dpLoad),
        .step_i (dpStep),
        .a_i    (selA),
        .b_i    (selB),
        .prod_o (prod)
    );

`ifdef MULT_PERF_CNT_EN
    logic [15:0] opsDone_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opsDone_q <= '0;
        end else if (respHs && (opsDone_q != 16'hFFFF)) begin
            opsDone_q <= opsDone_q + 16'd1;
        end
    end

    assign ops_done = opsDone_q;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed scenarios plus random traffic
// scored against a transaction-level model (product = a*b, round-robin, fixed latency).
module tb_mult_share_ctrl;

    localparam int WIDTH = 4;
    localparam int LAT   = WIDTH + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]             reqValid;
    logic [1:0]             respReady;
    logic [1:0][WIDTH-1:0]  opA;
    logic [1:0][WIDTH-1:0]  opB;

    logic               c0_req_ready, c1_req_ready;
    logic               c0_resp_valid, c1_resp_valid;
    logic [2*WIDTH-1:0] c0_result, c1_result;
    logic               busy;
    logic               grant_id;
`ifdef MULT_PERF_CNT_EN
    logic [15:0]        ops_done;
`endif

    always #5 clk = ~clk;

    mult_share_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .c0_req_valid  (reqValid[0]),
        .c0_req_ready  (c0_req_ready),
        .c0_a          (opA[0]),
        .c0_b          (opB[0]),
        .c0_resp_valid (c0_resp_valid),
        .c0_resp_ready (respReady[0]),
        .c0_result     (c0_result),
        .c1_req_valid  (reqValid[1]),
        .c1_req_ready  (c1_req_ready),
        .c1_a          (opA[1]),
        .c1_b          (opB[1]),
        .c1_resp_valid (c1_resp_valid),
        .c1_resp_ready (respReady[1]),
        .c1_result     (c1_result),
        .busy          (busy),
        .grant_id      (grant_id)
`ifdef MULT_PERF_CNT_EN
        ,
        .ops_done      (ops_done)
`endif
    );

    int checkCount = 0;
    int errorCount = 0;
    int cycleN     = 0;

    // Transaction-level reference state.
    int ptrModel    = 0;
    int inFlight    = 0;
    int ownerModel  = 0;
    int acceptCycle = 0;
    int opsModel    = 0;
    int expProd     = 0;
    int lastResult [2];
    int served [$];
    bit checkZero   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycleN);
        end
    endtask

    task automatic issue(input int c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        reqValid[c] = 1'b1;
        opA[c]      = a;
        opB[c]      = b;
    endtask

    // One clock cycle: sample at negedge, score against the model, advance the model.
    task automatic applyStimulus();
        logic [1:0]         rdy;
        logic [1:0]         rv;
        logic [2*WIDTH-1:0] res [2];
        int win;
        int dropValid;
        bit due;
        dropValid = -1;
        @(negedge clk);
        rdy    = {c1_req_ready, c0_req_ready};
        rv     = {c1_resp_valid, c0_resp_valid};
        res[0] = c0_result;
        res[1] = c1_result;
        if (!rst_n) begin
            inFlight = 0;
            ptrModel = 0;
            opsModel = 0;
        end else begin
`ifdef MULT_PERF_CNT_EN
            checkOutput("ops_done", ops_done, opsModel);
`endif
            if (checkZero) begin
                checkOutput("c0_result_zero", res[0], 0);
                checkOutput("c1_result_zero", res[1], 0);
                checkZero = 1'b0;
            end
            if (!inFlight) begin
                if (reqValid == 2'b01)      win = 0;
                else if (reqValid == 2'b10) win = 1;
                else                        win = ptrModel;
                checkOutput("c0_req_ready", rdy[0], (reqValid != 0) && (win == 0));
                checkOutput("c1_req_ready", rdy[1], (reqValid != 0) && (win == 1));
                checkOutput("busy_idle", busy, 0);
                checkOutput("grant_idle", grant_id, 0);
                checkOutput("resp_valid_idle", rv, 0);
                if (reqValid != 0) begin
                    inFlight    = 1;
                    ownerModel  = win;
                    acceptCycle = cycleN;
                    expProd     = int'(opA[win]) * int'(opB[win]);
                    dropValid   = win;
                end
            end else begin
                due = (cycleN - acceptCycle) >= LAT;
                checkOutput("req_ready_busy", rdy, 0);
                checkOutput("busy_active", busy, 1);
                checkOutput("grant_id", grant_id, ownerModel);
                checkOutput("resp_valid_owner", rv[ownerModel], due);
                checkOutput("resp_valid_other", rv[1-ownerModel], 0);
                if (due) begin
                    checkOutput("result", res[ownerModel], expProd);
                    if (respReady[ownerModel]) begin
                        lastResult[ownerModel] = int'(res[ownerModel]);
                        served.push_back(ownerModel);
                        ptrModel = 1 - ownerModel;
                        inFlight = 0;
                        opsModel++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cycleN++;
        if (dropValid >= 0) reqValid[dropValid] = 1'b0;
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int n;
        n = 0;
        while ((inFlight != 0 || reqValid != 0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_timeout", (inFlight != 0 || reqValid != 0), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '0;
        respReady = '0;
        opA       = '0;
        opB       = '0;
        repeat (2) applyStimulus();
        rst_n     = 1'b1;
        checkZero = 1'b1;
        applyStimulus();

        // Simultaneous requests straight after reset: c0, then c1, then c0 again.
        respReady = 2'b11;
        served.delete();
        issue(0, 4'd15, 4'd15);
        issue(1, 4'd3, 4'd4);
        runUntilIdle(40);
        issue(0, 4'd7, 4'd6);
        issue(1, 4'd2, 4'd9);
        runUntilIdle(40);
        checkOutput("served_count", served.size(), 4);
        if (served.size() == 4) begin
            checkOutput("first_grant", served[0], 0);
            checkOutput("second_grant", served[1], 1);
            checkOutput("third_grant", served[2], 0);
        end
`ifdef MULT_PERF_CNT_EN
        checkOutput("ops_after_four", opsModel, 4);
`endif

        // Single client.
        issue(0, 4'd13, 4'd11);
        runUntilIdle(20);
        checkOutput("single_c0", lastResult[0], 32'h8F);

        issue(0, 4'd15, 4'd15);
        runUntilIdle(20);
        checkOutput("c0_15x15", lastResult[0], 32'hE1);
        issue(1, 4'd3, 4'd4);
        runUntilIdle(20);
        checkOutput("c1_3x4", lastResult[1], 32'h0C);

        // Backpressure on c1 while c0 waits.
        respReady = 2'b01;
        issue(1, 4'd5, 4'd7);
        repeat (LAT + 1) applyStimulus();
        issue(0, 4'd2, 4'd3);
        repeat (10) applyStimulus();
        respReady = 2'b11;
        runUntilIdle(40);
        checkOutput("bp_c1", lastResult[1], 32'd35);
        checkOutput("bp_c0", lastResult[0], 32'd6);

        // Zero and identity operands.
        issue(0, 4'd0, 4'd9);
        runUntilIdle(20);
        checkOutput("zero_a", lastResult[0], 32'h00);
        issue(0, 4'd1, 4'd15);
        runUntilIdle(20);
        checkOutput("ident", lastResult[0], 32'h0F);
        issue(0, 4'd15, 4'd0);
        runUntilIdle(20);
        checkOutput("zero_b", lastResult[0], 32'h00);

        // Reset during the second CALC cycle aborts the operation.
        lastResult[0] = -1;
        issue(0, 4'd9, 4'd9);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        rst_n     = 1'b1;
        checkZero = 1'b1;
        applyStimulus();
        checkOutput("aborted_no_resp", lastResult[0], 32'hFFFF_FFFF);
        issue(1, 4'd6, 4'd7);
        runUntilIdle(20);
        checkOutput("after_reset_c1", lastResult[1], 32'd42);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!reqValid[c] && $urandom_range(0, 2) == 0) begin
                    issue(c, WIDTH'($urandom), WIDTH'($urandom));
                end
                respReady[c] = 1'($urandom_range(0, 1));
            end
            applyStimulus();
        end
        respReady = 2'b11;
        runUntilIdle(60);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
